cpl_request_lookup: RTL and testbench

Read-side counterpart of the Request Recorder write path in the AXI slave bridge. It accepts completion descriptors from the TL receive side and reads the recorded request entry indexed by the completion tag. It then routes the result to the AXI write-response (B) or read-response (R control) path. On the final completion for a tag, it releases that recorder entry.

---
 rtl/tl_axi_slave_pkg.sv | 41 ++++
 rtl/cpl_request_lookup_if.sv | 59 +++++
 rtl/cpl_request_lookup.sv | 159 +++++++++++++++
 tb/tb_cpl_request_lookup.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_axi_slave_pkg.sv
// Shared types for the AXI slave bridge: request-recorder entry layout, AXI/PCIe
// status encodings and the completion-status to AXI response mapping.
package tl_axi_slave_pkg;

  localparam int REC_ID_W  = 4;
  localparam int REC_LEN_W = 8;

  typedef struct packed {
    logic                 valid;
    logic                 is_write;
    logic [REC_ID_W-1:0]  axi_id;
    logic [REC_LEN_W-1:0] len;
  } req_rec_entry_t;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    CPL_SC  = 3'b000,
    CPL_UR  = 3'b001,
    CPL_CRS = 3'b010,
    CPL_CA  = 3'b100
  } cpl_status_e;

  // Unsupported request is an address decode miss; everything else non-SC is a slave error.
  function automatic axi_resp_e cpl_to_axi_resp(input logic [2:0] status);
    axi_resp_e resp;
    case (status)
      CPL_SC:          resp = AXI_OKAY;
      CPL_UR:          resp = AXI_DECERR;
      CPL_CRS, CPL_CA: resp = AXI_SLVERR;
      default:         resp = AXI_SLVERR;
    endcase
    return resp;
  endfunction

endpackage

// File: rtl/cpl_request_lookup_if.sv
// Completion-lookup bundle: completion descriptor in, recorder read/free port,
// and the B / R-control response channels. slave = lookup block, master = its environment.
interface cpl_request_lookup_if
  import tl_axi_slave_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int ID_W  = REC_ID_W,
  parameter int LEN_W = REC_LEN_W
);

  logic             cpl_valid;
  logic             cpl_ready;
  logic [TAG_W-1:0] cpl_tag;
  logic [2:0]       cpl_status;
  logic             cpl_last;

  logic             req_rd_en;
  logic [TAG_W-1:0] req_rd_addr;
  req_rec_entry_t   req_rd_data;
  logic             req_free_en;
  logic [TAG_W-1:0] req_free_tag;

  logic             wr_rsp_valid;
  logic             wr_rsp_ready;
  logic [ID_W-1:0]  wr_rsp_id;
  logic [1:0]       wr_rsp_resp;

  logic             rd_rsp_valid;
  logic             rd_rsp_ready;
  logic [ID_W-1:0]  rd_rsp_id;
  logic [1:0]       rd_rsp_resp;
  logic [LEN_W-1:0] rd_rsp_len;
  logic             rd_rsp_last;

  logic             err_unexpected;

  modport slave (
    input  cpl_valid, cpl_tag, cpl_status, cpl_last,
    input  req_rd_data,
    input  wr_rsp_ready, rd_rsp_ready,
    output cpl_ready,
    output req_rd_en, req_rd_addr, req_free_en, req_free_tag,
    output wr_rsp_valid, wr_rsp_id, wr_rsp_resp,
    output rd_rsp_valid, rd_rsp_id, rd_rsp_resp, rd_rsp_len, rd_rsp_last,
    output err_unexpected
  );

  modport master (
    output cpl_valid, cpl_tag, cpl_status, cpl_last,
    output req_rd_data,
    output wr_rsp_ready, rd_rsp_ready,
    input  cpl_ready,
    input  req_rd_en, req_rd_addr, req_free_en, req_free_tag,
    input  wr_rsp_valid, wr_rsp_id, wr_rsp_resp,
    input  rd_rsp_valid, rd_rsp_id, rd_rsp_resp, rd_rsp_len, rd_rsp_last,
    input  err_unexpected
  );

endinterface

// File: rtl/cpl_request_lookup.sv
// Reads the recorder entry for each completion tag and routes an AXI B or R-control response.
// Accept at T, response valid from T+3 (error pulse T+2); single completion in flight, cpl_ready low until handshake.
module cpl_request_lookup
  import tl_axi_slave_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int ID_W  = REC_ID_W,
  parameter int LEN_W = REC_LEN_W
) (
  input logic                 clk,
  input logic                 arst_n,
  cpl_request_lookup_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    DECODE = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e           state;

  // Completion captured on accept
  logic [TAG_W-1:0] tag_q;
  logic [2:0]       status_q;
  logic             last_q;

  // Recorder entry and mapped status, registered in LOOKUP
  logic             ent_valid_q;
  logic             ent_write_q;
  logic [ID_W-1:0]  ent_id_q;
  logic [LEN_W-1:0] ent_len_q;
  axi_resp_e        ent_resp_q;

  // Registered outputs
  logic             cpl_ready_q;
  logic             wr_vld_q;
  logic             rd_vld_q;
  logic [ID_W-1:0]  rsp_id_q;
  axi_resp_e        rsp_resp_q;
  logic [LEN_W-1:0] rsp_len_q;
  logic             rsp_last_q;
  logic             err_q;

  logic             accept;
  logic             wr_hs;
  logic             rd_hs;

  // cpl_ready_q is only ever high in IDLE, so it doubles as the accept window.
  assign accept = bus.cpl_valid && cpl_ready_q;
  assign wr_hs  = wr_vld_q && bus.wr_rsp_ready;
  assign rd_hs  = rd_vld_q && bus.rd_rsp_ready;

  assign bus.cpl_ready      = cpl_ready_q;
  assign bus.req_rd_en      = accept;
  assign bus.req_rd_addr    = accept ? bus.cpl_tag : '0;

  // A write is always a single completion, so its handshake releases the entry unconditionally.
  assign bus.req_free_en    = wr_hs || (rd_hs && last_q);
  assign bus.req_free_tag   = bus.req_free_en ? tag_q : '0;

  assign bus.wr_rsp_valid   = wr_vld_q;
  assign bus.wr_rsp_id      = rsp_id_q;
  assign bus.wr_rsp_resp    = rsp_resp_q;
  assign bus.rd_rsp_valid   = rd_vld_q;
  assign bus.rd_rsp_id      = rsp_id_q;
  assign bus.rd_rsp_resp    = rsp_resp_q;
  assign bus.rd_rsp_len     = rsp_len_q;
  assign bus.rd_rsp_last    = rsp_last_q;
  assign bus.err_unexpected = err_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      tag_q       <= '0;
      status_q    <= '0;
      last_q      <= 1'b0;
      ent_valid_q <= 1'b0;
      ent_write_q <= 1'b0;
      ent_id_q    <= '0;
      ent_len_q   <= '0;
      ent_resp_q  <= AXI_OKAY;
      cpl_ready_q <= 1'b0;
      wr_vld_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      rsp_id_q    <= '0;
      rsp_resp_q  <= AXI_OKAY;
      rsp_len_q   <= '0;
      rsp_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          cpl_ready_q <= 1'b1;
          if (accept) begin
            tag_q       <= bus.cpl_tag;
            status_q    <= bus.cpl_status;
            last_q      <= bus.cpl_last;
            cpl_ready_q <= 1'b0;
            state       <= LOOKUP;
          end
        end

        LOOKUP: begin
          ent_valid_q <= bus.req_rd_data.valid;
          ent_write_q <= bus.req_rd_data.is_write;
          ent_id_q    <= bus.req_rd_data.axi_id;
          ent_len_q   <= bus.req_rd_data.len;
          ent_resp_q  <= cpl_to_axi_resp(status_q);
          // Raised here so the pulse lands in the DECODE cycle.
          err_q       <= !bus.req_rd_data.valid;
          state       <= DECODE;
        end

        DECODE: begin
          if (!ent_valid_q) begin
            cpl_ready_q <= 1'b1;
            state       <= IDLE;
          end else begin
            wr_vld_q    <= ent_write_q;
            rd_vld_q    <= !ent_write_q;
            rsp_id_q    <= ent_id_q;
            rsp_resp_q  <= ent_resp_q;
            rsp_len_q   <= ent_len_q;
            rsp_last_q  <= last_q;
            state       <= RESP;
          end
        end

        RESP: begin
          if (wr_hs || rd_hs) begin
            wr_vld_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
            cpl_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_one_channel: assert property (@(posedge clk) disable iff (!arst_n)
    !(wr_vld_q && rd_vld_q));

  a_wr_hold: assert property (@(posedge clk) disable iff (!arst_n)
    (wr_vld_q && !bus.wr_rsp_ready) |=> (wr_vld_q && $stable(rsp_id_q) && $stable(rsp_resp_q)));

  a_rd_hold: assert property (@(posedge clk) disable iff (!arst_n)
    (rd_vld_q && !bus.rd_rsp_ready) |=>
      (rd_vld_q && $stable(rsp_id_q) && $stable(rsp_resp_q) && $stable(rsp_len_q) && $stable(rsp_last_q)));

  a_ready_only_idle: assert property (@(posedge clk) disable iff (!arst_n)
    cpl_ready_q |-> (state == IDLE));

endmodule

// File: tb/tb_cpl_request_lookup.sv
// Randomized scoreboard bench for cpl_request_lookup with a recorder memory model.
module tb_cpl_request_lookup;
  import tl_axi_slave_pkg::*;

  localparam int TAG_W = 8;
  localparam int ID_W  = 4;
  localparam int LEN_W = 8;
  localparam int BOUND = 200;
  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]       kind;
    logic [ID_W-1:0]  id;
    logic [1:0]       resp;
    logic [LEN_W-1:0] len;
    logic             last;
    logic             free;
    logic [TAG_W-1:0] ftag;
    int               t_acc;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  cpl_request_lookup_if #(.TAG_W(TAG_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

  cpl_request_lookup #(.TAG_W(TAG_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  req_rec_entry_t mem [256];
  exp_t           exp_q [$];
  int             n_cmp = 0;
  int             n_fail = 0;
  int             cyc = 0;
  int             last_hs_cyc = 0;
  int             wr_mode = 1;   // 0 random, 1 always ready, 2 never ready
  int             rd_mode = 1;
  bit             rsp_seen = 0;
  bit             ready_next_chk = 0;
  exp_t           mon_e;
  logic [1:0]     obs_kind;
  bit             hs;
  logic           rd_pend;
  logic [TAG_W-1:0] rd_pend_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic finish_sim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  task automatic chk_zero(input string name);
    chk(name, 64'({bus.cpl_ready, bus.req_rd_en, bus.req_rd_addr, bus.req_free_en, bus.req_free_tag,
                   bus.wr_rsp_valid, bus.wr_rsp_id, bus.wr_rsp_resp,
                   bus.rd_rsp_valid, bus.rd_rsp_id, bus.rd_rsp_resp, bus.rd_rsp_len, bus.rd_rsp_last,
                   bus.err_unexpected}), 64'd0);
  endtask

  // Reference behaviour: what one completion must produce, straight from the entry contents.
  function automatic exp_t model(input req_rec_entry_t ent, input logic [TAG_W-1:0] tag,
                                 input logic [2:0] st, input logic last, input int t);
    exp_t e;
    e = '0;
    e.t_acc = t;
    if (!ent.valid) begin
      e.kind = K_ERR;
      return e;
    end
    e.kind = ent.is_write ? K_WR : K_RD;
    e.id   = ent.axi_id;
    e.len  = ent.len;
    e.last = last;
    e.resp = (st == 3'b000) ? 2'b00 : (st == 3'b001) ? 2'b11 : 2'b10;
    e.free = ent.is_write || last;
    e.ftag = tag;
    return e;
  endfunction

  task automatic send(input logic [TAG_W-1:0] tag, input logic [2:0] st, input logic last, output int t_acc);
    int n;
    logic [31:0] r;
    @(posedge clk); #1;
    bus.cpl_valid  = 1'b1;
    bus.cpl_tag    = tag;
    bus.cpl_status = st;
    bus.cpl_last   = last;
    n = 0;
    @(negedge clk);
    while (!bus.cpl_ready) begin
      n++;
      if (n > BOUND) begin
        chk("cpl_ready_timeout", 64'(bus.cpl_ready), 64'd1);
        finish_sim();
      end
      @(negedge clk);
    end
    t_acc = cyc;
    exp_q.push_back(model(mem[tag], tag, st, last, cyc));
    @(posedge clk); #1;
    r = $urandom;
    bus.cpl_valid  = 1'b0;
    bus.cpl_tag    = r[7:0];
    bus.cpl_status = r[10:8];
    bus.cpl_last   = r[11];
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk); #1;
      n++;
      if (n > BOUND) begin
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        finish_sim();
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic wait_valid(input bit is_wr, output int v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_wr ? bus.wr_rsp_valid : bus.rd_rsp_valid) && n < BOUND);
    if (!(is_wr ? bus.wr_rsp_valid : bus.rd_rsp_valid)) begin
      chk("rsp_valid_timeout", 64'd0, 64'd1);
      finish_sim();
    end
    v = cyc;
  endtask

  // Recorder RAM model: data presented for exactly the cycle after the read strobe.
  initial begin
    logic [31:0] r;
    bus.req_rd_data = '0;
    rd_pend = 1'b0;
    rd_pend_addr = '0;
    forever begin
      @(negedge clk);
      rd_pend = bus.req_rd_en;
      rd_pend_addr = bus.req_rd_addr;
      @(posedge clk); #1;
      r = $urandom;
      bus.req_rd_data = rd_pend ? mem[rd_pend_addr] : r[$bits(req_rec_entry_t)-1:0];
    end
  end

  initial begin
    bus.wr_rsp_ready = 1'b0;
    bus.rd_rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.wr_rsp_ready = (wr_mode == 1) || (wr_mode == 0 && $urandom_range(0, 2) != 0);
      bus.rd_rsp_ready = (rd_mode == 1) || (rd_mode == 0 && $urandom_range(0, 2) != 0);
    end
  end

  // Monitor: compares every cycle an output is presented against the head of the expected queue.
  always @(negedge clk) begin
    if (!arst_n) begin
      rsp_seen = 0;
      ready_next_chk = 0;
    end else begin
      hs = 0;
      if (ready_next_chk) begin
        chk("cpl_ready_reopen", 64'(bus.cpl_ready), 64'd1);
        ready_next_chk = 0;
      end
      chk("req_rd_en", 64'(bus.req_rd_en), 64'(bus.cpl_valid && bus.cpl_ready));
      if (bus.req_rd_en) chk("req_rd_addr", 64'(bus.req_rd_addr), 64'(bus.cpl_tag));
      if (bus.wr_rsp_valid || bus.rd_rsp_valid || bus.err_unexpected) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'({bus.wr_rsp_valid, bus.rd_rsp_valid, bus.err_unexpected}), 64'd0);
        end else begin
          mon_e = exp_q[0];
          obs_kind = bus.err_unexpected ? K_ERR : (bus.wr_rsp_valid ? K_WR : K_RD);
          chk("one_output", 64'(bus.wr_rsp_valid) + 64'(bus.rd_rsp_valid) + 64'(bus.err_unexpected), 64'd1);
          chk("rsp_kind", 64'(obs_kind), 64'(mon_e.kind));
          chk("cpl_ready_busy", 64'(bus.cpl_ready), 64'd0);
          if (!rsp_seen) begin
            chk("first_output_latency", 64'(cyc - mon_e.t_acc), (mon_e.kind == K_ERR) ? 64'd2 : 64'd3);
            rsp_seen = 1;
          end
          if (obs_kind == K_WR) begin
            chk("wr_fields", 64'({bus.wr_rsp_id, bus.wr_rsp_resp}), 64'({mon_e.id, mon_e.resp}));
            hs = bus.wr_rsp_ready;
          end else if (obs_kind == K_RD) begin
            chk("rd_fields", 64'({bus.rd_rsp_id, bus.rd_rsp_resp, bus.rd_rsp_len, bus.rd_rsp_last}),
                64'({mon_e.id, mon_e.resp, mon_e.len, mon_e.last}));
            hs = bus.rd_rsp_ready;
          end else begin
            hs = 1;
          end
          if (hs) begin
            chk("free_en", 64'(bus.req_free_en), 64'(mon_e.free));
            if (mon_e.free) chk("free_tag", 64'(bus.req_free_tag), 64'(mon_e.ftag));
            void'(exp_q.pop_front());
            rsp_seen = 0;
            ready_next_chk = 1;
            last_hs_cyc = cyc;
          end
        end
      end
      if (!hs) chk("stray_free", 64'(bus.req_free_en), 64'd0);
    end
  end

  initial begin
    int t;
    int v;
    logic [31:0] r;
    logic [2:0] st_list [4];
    logic [2:0] st;
    st_list[0] = 3'b001;
    st_list[1] = 3'b100;
    st_list[2] = 3'b010;
    st_list[3] = 3'b111;

    bus.cpl_valid  = 1'b0;
    bus.cpl_tag    = '0;
    bus.cpl_status = '0;
    bus.cpl_last   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      mem[i].valid    = (r[2:0] != 3'd0);
      mem[i].is_write = r[3];
      mem[i].axi_id   = r[7:4];
      mem[i].len      = r[15:8];
    end

    // Reset state and release timing
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(negedge clk);
    chk("cpl_ready_before_edge", 64'(bus.cpl_ready), 64'd0);
    @(negedge clk);
    chk("cpl_ready_after_release", 64'(bus.cpl_ready), 64'd1);

    // Write hit with ready already high
    mem[5] = '{valid: 1'b1, is_write: 1'b1, axi_id: 4'd3, len: 8'd0};
    send(8'd5, 3'b000, 1'b1, t);
    drain();
    chk("wr_hit_hs_cycle", 64'(last_hs_cyc - t), 64'd3);

    // Read with two completions on the same tag
    mem[9] = '{valid: 1'b1, is_write: 1'b0, axi_id: 4'd7, len: 8'd15};
    send(8'd9, 3'b000, 1'b0, t);
    drain();
    send(8'd9, 3'b000, 1'b1, t);
    drain();

    // Backpressure: ready low for 6 response cycles
    rd_mode = 2;
    send(8'd9, 3'b000, 1'b1, t);
    wait_valid(1'b0, v);
    repeat (5) @(negedge clk);
    rd_mode = 1;
    @(negedge clk); #1;
    chk("bp_hs_cycle", 64'(last_hs_cyc - v), 64'd6);
    drain();

    // Status mapping on a read entry
    mem[20] = '{valid: 1'b1, is_write: 1'b0, axi_id: 4'd10, len: 8'd3};
    for (int k = 0; k < 4; k++) begin
      send(8'd20, st_list[k], 1'b1, t);
      drain();
    end

    // Completion against an unrecorded entry
    mem[2] = '0;
    send(8'd2, 3'b000, 1'b1, t);
    drain();

    // Reset while a write response is waiting
    wr_mode = 2;
    send(8'd5, 3'b000, 1'b1, t);
    wait_valid(1'b1, v);
    @(posedge clk); #1;
    arst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_zero("reset_mid_resp");
    repeat (2) @(negedge clk);
    chk_zero("reset_mid_resp_hold");
    @(posedge clk); #1;
    arst_n = 1'b1;
    wr_mode = 1;
    @(negedge clk);
    chk("cpl_ready_before_edge2", 64'(bus.cpl_ready), 64'd0);
    @(negedge clk);
    chk("cpl_ready_after_release2", 64'(bus.cpl_ready), 64'd1);

    // Randomized traffic with random backpressure
    wr_mode = 0;
    rd_mode = 0;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0:       st = 3'b000;
        1:       st = 3'b001;
        2:       st = 3'b010;
        3:       st = 3'b100;
        default: begin r = $urandom; st = r[2:0]; end
      endcase
      r = $urandom;
      send(r[7:0], st, r[8], t);
      if (r[10:9] == 2'd0) drain();
    end
    wr_mode = 1;
    rd_mode = 1;
    drain();

    finish_sim();
  end

endmodule
